uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default CLOCK_RATE / BAUD_RATE from definitions_pkg, clk cycles per serial bit (minimum 2).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on posedge clk; one clock domain.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: enabled  input  1  block enable; low aborts and holds idle.
REQ-005 SHALL have port: start  input  1  request to send `in`; sampled each clk.
REQ-006 SHALL have port: in  input  8  parallel byte to transmit, LSB first.
REQ-007 SHALL have port: out  output  1  tx line; idles high.
REQ-008 SHALL have port: busy  output  1  frame in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse at end of stop bit.

Function
REQ-010 SHALL transmit 8N1 frames: start bit (0), data bits in[0]..in[7], one stop bit (1).
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP (enum in package).
REQ-012 SHALL accept a request in IDLE when start=1 and enabled=1; it SHALL latch in into a shift register that same edge and enter START.
REQ-013 SHALL drive out=0 and busy=1 from the first cycle after acceptance (latency 1 clk).
REQ-014 SHALL hold each bit on out for exactly CLKS_PER_BIT clk cycles, timed by a bit counter cleared on acceptance and on each bit boundary; the counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap at CLKS_PER_BIT-1.
REQ-015 SHALL index data bits with a 3-bit counter; DATA→STOP when index 7 completes, with no wrap into a ninth bit.
REQ-016 SHALL make a full frame occupy 10*CLKS_PER_BIT cycles, from busy rise to the done pulse.
REQ-017 SHALL, on the final cycle of STOP, go to IDLE, drop busy and pulse done=1 for one cycle on the next edge.
REQ-018 SHALL accept start asserted in the done cycle (back-to-back), beginning the next start bit with no idle bit.
REQ-019 SHALL ignore start while busy=1; in changes during a frame SHALL not affect it.
REQ-020 SHALL, when enabled=0 in any state, on the next edge set state IDLE, out=1, busy=0, done=0 and clear the counters; the aborted frame SHALL not signal done.
REQ-021 SHALL register out, busy and done (glitch-free tx line).

Reset
REQ-022 SHALL, while rst=1, asynchronously force state=IDLE, out=1, busy=0, done=0, shift register=8'h00, bit and index counters=0.
REQ-023 SHALL, on rst asserted mid-frame, drop the frame without a done pulse; after release the block SHALL be idle and accept start on the first edge.

Structure
REQ-024 SHALL keep in definitions_pkg: CLOCK_RATE and BAUD_RATE (shared with receiver) and the tx state enum typedef.
REQ-025 SHALL be a single module with no sub-module; the bit timer SHALL be inline.

Verification (CLKS_PER_BIT=4 in bench)
REQ-026 SHALL check: in=8'hA5, start pulse → out sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy high 40 cycles; done one pulse at cycle 41.
REQ-027 SHALL check: start held high continuously with in=8'h00 then 8'hFF → two contiguous frames, no idle gap; second frame starts in the done cycle.
REQ-028 SHALL check: start pulsed at cycle 10 of a frame carrying 8'h3C → ignored; frame bits unchanged; only one done.
REQ-029 SHALL check: enabled dropped during DATA bit 3 → out=1, busy=0 next cycle; no done; a new start after re-enable sends a clean frame.
REQ-030 SHALL check: rst asserted mid-STOP asynchronously (between clk edges) → out=1, busy=0, done=0 immediately; first post-reset start transmits 8'h5A correctly.
REQ-031 SHALL check, with a loopback into the existing receiver: bytes 8'h00, 8'h55, 8'hFF round-trip with matching data and no err.

Source files
------------

// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared serial-link constants and the transmitter state type
package definitions_pkg;

  localparam int CLOCK_RATE = 50_000_000;
  localparam int BAUD_RATE  = 115_200;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte request / serial line bundle for the UART transmitter
interface uart_transmitter_if;

  logic       enabled;
  logic       start;
  logic [7:0] in;
  logic       out;
  logic       busy;
  logic       done;

  modport master (
    output enabled, start, in,
    input  out, busy, done
  );

  modport slave (
    input  enabled, start, in,
    output out, busy, done
  );

endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter, LSB first, registered tx line
module uart_transmitter
  import definitions_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input  logic              clk,
  input  logic              rst,
  uart_transmitter_if.slave bus
);

  localparam int              CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LP_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_out;
  logic          r_busy;
  logic          r_done;

  logic          w_bit_end;
  logic [2:0]    w_idx_next;

  assign w_bit_end  = (r_cnt == LP_LAST);
  assign w_idx_next = r_idx + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_out   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!bus.enabled) begin
      // Abort silently: the dropped frame must never report done.
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_out   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= w_bit_end ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.start) begin
            r_state <= START;
            r_shift <= bus.in;
            r_idx   <= 3'd0;
            r_out   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_idx   <= 3'd0;
            r_out   <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              r_out   <= 1'b1;
            end else begin
              r_idx <= w_idx_next;
              r_out <= r_shift[w_idx_next];
            end
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter with a line-decoding scoreboard
module tb_uart_transmitter;

  logic clk = 1'b0;
  logic rst;

  uart_transmitter_if bus ();

  uart_transmitter #(.CLKS_PER_BIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_vec   = 0;
  int         n_err   = 0;
  int         rx_good = 0;
  logic [7:0] exp_q[$];

  // Expected tx line level in cycle k (1-based, k=1 is the first cycle after acceptance).
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int idx;
    idx = (k - 1) / 4;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Line receiver: samples mid-bit, discards frames during which busy dropped.
  always begin
    logic       ok;
    logic [7:0] data;
    logic       stop;
    logic [7:0] e;
    @(negedge clk);
    if (bus.out === 1'b0 && bus.busy === 1'b1) begin
      ok = 1'b1;
      repeat (2) @(negedge clk);
      if (bus.out !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        data[i] = bus.out;
        if (bus.busy !== 1'b1) ok = 1'b0;
      end
      repeat (4) @(negedge clk);
      stop = bus.out;
      if (bus.busy !== 1'b1) ok = 1'b0;
      if (ok) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rx_unexpected: got byte %h, required no frame", data);
        end else begin
          e = exp_q.pop_front();
          rx_good++;
          if ({stop, data} !== {1'b1, e}) begin
            n_err++;
            $display("FAIL rx_byte: got stop=%b data=%h, required stop=1 data=%h", stop, data, e);
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst         = 1'b1;
    bus.enabled = 1'b1;
    bus.start   = 1'b0;
    bus.in      = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got out/busy/done=%b%b%b, required 100", bus.out, bus.busy, bus.done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got out/busy/done=%b%b%b, required 100", bus.out, bus.busy, bus.done);
    end
  endtask

  task automatic test_single_frame;
    exp_q.push_back(8'hA5);
    bus.in    = 8'hA5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 42; k++) begin
      n_vec++;
      if (k <= 40) begin
        if (bus.out !== exp_line(8'hA5, k) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL a5_frame cycle %0d: got out/busy/done=%b%b%b, required %b10",
                   k, bus.out, bus.busy, bus.done, exp_line(8'hA5, k));
        end
      end else if (k == 41) begin
        if (bus.out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin
          n_err++;
          $display("FAIL a5_done: got out/busy/done=%b%b%b, required 101", bus.out, bus.busy, bus.done);
        end
      end else begin
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL a5_after: got busy/done=%b%b, required 00", bus.busy, bus.done);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    bus.in    = 8'h00;
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 83; k++) begin
      n_vec++;
      if (k <= 40) begin
        if (bus.out !== exp_line(8'h00, k) || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_first cycle %0d: got out/busy=%b%b, required %b1", k, bus.out, bus.busy, exp_line(8'h00, k));
        end
      end else if (k == 41 || k == 82) begin
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_done cycle %0d: got busy/done=%b%b, required 01", k, bus.busy, bus.done);
        end
      end else if (k <= 81) begin
        if (bus.out !== exp_line(8'hFF, k - 41) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_second cycle %0d: got out/busy/done=%b%b%b, required %b10",
                   k, bus.out, bus.busy, bus.done, exp_line(8'hFF, k - 41));
        end
      end else begin
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_end: got busy/done=%b%b, required 00", bus.busy, bus.done);
        end
      end
      if (k == 2) bus.in = 8'hFF;
      if (k == 42) bus.start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int ndone;
    ndone = 0;
    exp_q.push_back(8'h3C);
    bus.in    = 8'h3C;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      if (bus.done === 1'b1) ndone++;
      if (k <= 40) begin
        n_vec++;
        if (bus.out !== exp_line(8'h3C, k) || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL ignore_frame cycle %0d: got out/busy=%b%b, required %b1", k, bus.out, bus.busy, exp_line(8'h3C, k));
        end
      end
      if (k == 10) begin
        bus.start = 1'b1;
        bus.in    = 8'hC3;
      end
      if (k == 11) bus.start = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (ndone != 1) begin
      n_err++;
      $display("FAIL ignore_done_count: got %0d, required 1", ndone);
    end
  endtask

  task automatic test_enable_abort;
    int dc;
    bus.in    = 8'h96;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      n_vec++;
      if (k <= 18) begin
        if (bus.out !== exp_line(8'h96, k) || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL abort_pre cycle %0d: got out/busy=%b%b, required %b1", k, bus.out, bus.busy, exp_line(8'h96, k));
        end
      end else begin
        if (bus.out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL abort_post cycle %0d: got out/busy/done=%b%b%b, required 100", k, bus.out, bus.busy, bus.done);
        end
      end
      if (k == 18) bus.enabled = 1'b0;
      @(negedge clk);
    end
    bus.enabled = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h96);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dc = -1;
    for (int k = 1; k <= 50; k++) begin
      if (bus.done === 1'b1 && dc < 0) dc = k;
      @(negedge clk);
    end
    n_vec++;
    if (dc != 41) begin
      n_err++;
      $display("FAIL reenable_done_cycle: got %0d, required 41", dc);
    end
  endtask

  task automatic test_async_reset;
    int dc;
    bus.in    = 8'hE7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (37) @(negedge clk);
    n_vec++;
    if (bus.out !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_in_stop: got out/busy=%b%b, required 11", bus.out, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got out/busy/done=%b%b%b, required 100", bus.out, bus.busy, bus.done);
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_held: got busy/done=%b%b, required 00", bus.busy, bus.done);
    end
    rst = 1'b0;
    exp_q.push_back(8'h5A);
    bus.in    = 8'h5A;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.out !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_first_start: got out/busy=%b%b, required 01", bus.out, bus.busy);
    end
    dc = -1;
    for (int k = 1; k <= 50; k++) begin
      if (bus.done === 1'b1 && dc < 0) dc = k;
      @(negedge clk);
    end
    n_vec++;
    if (dc != 41) begin
      n_err++;
      $display("FAIL rst_5a_done_cycle: got %0d, required 41", dc);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] bytes [3];
    bit         got;
    bytes[0] = 8'h00;
    bytes[1] = 8'h55;
    bytes[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]);
      bus.in    = bytes[i];
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      got = 1'b0;
      for (int k = 1; k <= 60 && !got; k++) begin
        @(negedge clk);
        if (bus.done === 1'b1) got = 1'b1;
      end
      n_vec++;
      if (!got) begin
        n_err++;
        $display("FAIL loopback_timeout byte %h: got no done, required done within 60 cycles", bytes[i]);
      end
    end
    repeat (5) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left: got %0d pending, required 0", exp_q.size());
    end
    n_vec++;
    if (rx_good != 9) begin
      n_err++;
      $display("FAIL rx_frame_count: got %0d, required 9", rx_good);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_ignore_start();
    test_enable_abort();
    repeat (3) @(negedge clk);
    test_async_reset();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, required completion");
    $fatal(1);
  end

endmodule
